// File: rtl/cim_seq_pkg.sv
// rtl/cim_seq_pkg.sv - shared opcodes, FSM states and address strides for the CIM sequencer
package cim_seq_pkg;

    localparam logic [1:0] OP_LOAD_W   = 2'b00;
    localparam logic [1:0] OP_MVM      = 2'b01;
    localparam logic [1:0] OP_READ_OUT = 2'b10;
    localparam logic [1:0] OP_MEM_RD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_ACC,
        S_DRAIN,
        S_MRD
    } state_t;

    // Byte strides between consecutive words of a weight load and of an MVM activation stream
    localparam logic [31:0] LOAD_STRIDE = 32'd4;
    localparam logic [31:0] ACC_STRIDE  = 32'd8;

endpackage

// File: rtl/cim_seq_res_buf.sv
// rtl/cim_seq_res_buf.sv - one-entry valid/ready result slot holding data and index
module cim_seq_res_buf #(
    parameter int DW = 32,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [IW-1:0] load_idx,
    output logic          free,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [IW-1:0] res_idx
);

    // Free when empty or being drained this cycle, so back-to-back results need no bubble
    assign free = !res_valid || res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else if (load && free) begin
            res_valid <= 1'b1;
            res_data  <= load_data;
            res_idx   <= load_idx;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cim_mvm_sequencer.sv
// rtl/cim_mvm_sequencer.sv - CIM GeMM macro command sequencer; perf counters built only with CIM_SEQ_PERF_EN
module cim_mvm_sequencer
    import cim_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_PAR    = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [3:0]           res_idx,
    output logic                 busy,
    output logic                 cim_cs,
    output logic                 cim_write,
    output logic                 cim_cim,
    output logic                 cim_partial_sum,
    output logic                 cim_reset_output,
    output logic [3:0]           cim_output_reg,
    output logic [31:0]          cim_address,
    output logic [31:0]          cim_input_data,
    input  logic [31:0]          cim_output,
    output logic [31:0]          perf_busy_cycles,
    output logic [31:0]          perf_stall_cycles
);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32 || OUT_PAR < 1 || OUT_PAR > 16 || LEN_WIDTH < 4) begin : g_bad_params
        $error("cim_mvm_sequencer: parameter out of range");
    end

    state_t               state;
    logic [31:0]          addr_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] k;
    logic [3:0]           idx;

    logic len_zero, last_k, in_fire, slot_free, capture;

    assign len_zero  = (len_q == '0);
    assign last_k    = (k == len_q - LEN_WIDTH'(1));
    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = ((state == S_LOAD) || (state == S_ACC)) && !len_zero;
    assign in_fire   = in_valid && in_ready;
    assign capture   = ((state == S_DRAIN) || ((state == S_MRD) && !len_zero)) && slot_free;
    assign busy      = (state != S_IDLE) || res_valid;

    always_comb begin
        cim_cs           = 1'b0;
        cim_write        = 1'b0;
        cim_cim          = 1'b0;
        cim_partial_sum  = 1'b0;
        cim_reset_output = 1'b0;
        cim_output_reg   = 4'd0;
        cim_address      = 32'd0;
        cim_input_data   = 32'd0;
        case (state)
            S_LOAD: if (!len_zero) begin
                cim_cs         = in_valid;
                cim_write      = 1'b1;
                cim_address    = addr_q + 32'(k) * LOAD_STRIDE;
                cim_input_data = in_data;
            end
            S_CLR: begin
                cim_cs           = 1'b1;
                cim_cim          = 1'b1;
                cim_reset_output = 1'b1;
            end
            S_ACC: begin
                cim_cs          = in_valid;
                cim_cim         = 1'b1;
                cim_partial_sum = 1'b1;
                cim_address     = addr_q + 32'(k) * ACC_STRIDE;
                cim_input_data  = in_data;
            end
            S_DRAIN: begin
                cim_cim        = 1'b1;
                cim_output_reg = idx;
            end
            S_MRD: if (!len_zero) begin
                cim_address = addr_q + 32'(k);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            k      <= '0;
            idx    <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    k      <= '0;
                    idx    <= '0;
                    case (cmd_op)
                        OP_LOAD_W:   state <= S_LOAD;
                        OP_MVM:      state <= S_CLR;
                        OP_READ_OUT: state <= S_DRAIN;
                        OP_MEM_RD:   state <= S_MRD;
                    endcase
                end
                S_LOAD: begin
                    if (len_zero) begin
                        state <= S_IDLE;
                    end else if (in_fire) begin
                        k <= k + LEN_WIDTH'(1);
                        if (last_k) state <= S_IDLE;
                    end
                end
                S_CLR: state <= len_zero ? S_DRAIN : S_ACC;
                S_ACC: if (in_fire) begin
                    k <= k + LEN_WIDTH'(1);
                    if (last_k) state <= S_DRAIN;
                end
                S_DRAIN: if (slot_free) begin
                    idx <= idx + 4'd1;
                    if (idx == 4'(OUT_PAR - 1)) state <= S_IDLE;
                end
                S_MRD: begin
                    if (len_zero) begin
                        state <= S_IDLE;
                    end else if (slot_free) begin
                        k <= k + LEN_WIDTH'(1);
                        if (last_k) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    cim_seq_res_buf #(.DW(32), .IW(4)) u_res_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_data (cim_output),
        .load_idx  ((state == S_DRAIN) ? idx : 4'(k)),
        .free      (slot_free),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx)
    );

`ifdef CIM_SEQ_PERF_EN
    logic stall;
    assign stall = (((state == S_LOAD) || (state == S_ACC)) && !in_valid) ||
                   (((state == S_DRAIN) || (state == S_MRD)) && res_valid && !res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1))   perf_busy_cycles  <= perf_busy_cycles + 32'd1;
            if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cim_mvm_sequencer.sv
// tb/tb_cim_mvm_sequencer.sv - scoreboard bench for cim_mvm_sequencer with a behavioural CIM macro
module tb_cim_mvm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_idx;
    logic        busy;
    logic        cim_cs, cim_write, cim_cim, cim_partial_sum, cim_reset_output;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_output;
    logic [31:0] perf_busy_cycles, perf_stall_cycles;

    int checks = 0;
    int failures = 0;

    logic [31:0] acc [8];
    logic [63:0] wr_log [$];
    logic [31:0] ps_log [$];
    logic [35:0] exp_q [$];
    int cs_count = 0;
    int clr_count = 0;
    int tb_busy = 0;
    logic       rdy_mode = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;
    int         rdy_ptr = 0;
    logic        held = 1'b0;
    logic [35:0] held_val;
    logic [31:0] exp5 [8] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72};

    always #5 clk = ~clk;

    cim_mvm_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .busy(busy),
        .cim_cs(cim_cs), .cim_write(cim_write), .cim_cim(cim_cim),
        .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_output(cim_output),
        .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Macro model: accumulators survive sequencer reset; reads with cim=0 return address+0x1000
    always_comb begin
        if (cim_cim) cim_output = acc[cim_output_reg[2:0]];
        else         cim_output = cim_address + 32'h1000;
    end

    initial for (int j = 0; j < 8; j++) acc[j] = 32'd0;

    always @(negedge clk) begin
        if (cim_cs) begin
            cs_count++;
            if (cim_write && !cim_cim) wr_log.push_back({cim_address, cim_input_data});
            if (cim_cim && cim_reset_output) begin
                for (int j = 0; j < 8; j++) acc[j] = 32'd0;
                clr_count++;
            end
            if (cim_cim && cim_partial_sum) begin
                ps_log.push_back(cim_address);
                for (int j = 0; j < 8; j++)
                    acc[j] = acc[j] + 32'(cim_input_data[31-4*j -: 4]) * 32'(j + 1);
            end
        end
        if (rst_n && busy) tb_busy++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (res_valid && held) chk("res_stable", 64'({res_idx, res_data}), 64'(held_val));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 64'({res_idx, res_data}), 64'hDEAD_0000_0000);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("res", 64'({res_idx, res_data}), 64'(e));
                end
                held = 1'b0;
            end else if (res_valid) begin
                held = 1'b1;
                held_val = {res_idx, res_data};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                res_ready = rdy_pat[rdy_ptr];
                rdy_ptr = (rdy_ptr + 1) % 4;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    task automatic push_res(input logic [3:0] i, input logic [31:0] d);
        exp_q.push_back({i, d});
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [7:0] l);
        int t = 0;
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        while (!ok && t < 200) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1; t++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int t = 0;
        logic ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d;
        while (!ok && t < 200) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; t++;
        end
        in_valid = 1'b0;
        chk("in_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(cmd_ready && !res_valid && exp_q.size() == 0) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk(name, 64'(t < 500), 64'd1);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'd0; cmd_len = 8'd0;
        in_valid = 1'b0; in_data = 32'd0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ctrl", 64'({cmd_ready, busy, res_valid, in_ready}), 64'b1000);
        chk("rst_res", 64'({res_idx, res_data}), 64'd0);
        chk("rst_cim", 64'({cim_cs, cim_write, cim_cim, cim_partial_sum, cim_reset_output, cim_output_reg}), 64'd0);
        chk("rst_cim_bus", {cim_address, cim_input_data}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        wr_log.delete();
        send_cmd(2'b00, 32'h80, 8'd2);
        send_word(32'h01020304, 0);
        send_word(32'h05060708, 0);
        @(negedge clk);
        chk("load_ready_back", 64'(cmd_ready), 64'd1);
        chk("load_wr_count", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            chk("load_wr0", wr_log[0], 64'h0000_0080_0102_0304);
            chk("load_wr1", wr_log[1], 64'h0000_0084_0506_0708);
        end
        @(posedge clk); #1;

        ps_log.delete(); c0 = clr_count;
        for (int j = 0; j < 8; j++) push_res(4'(j), 32'(j + 1));
        send_cmd(2'b01, 32'h0, 8'd1);
        send_word(32'h11111111, 2);
        wait_idle("mvm1_done");
        chk("mvm1_clr", 64'(clr_count - c0), 64'd1);
        chk("mvm1_ps_count", 64'(ps_log.size()), 64'd1);
        if (ps_log.size() == 1) chk("mvm1_ps_addr", 64'(ps_log[0]), 64'd0);

        for (int j = 0; j < 8; j++) push_res(4'(j), 32'(j + 1));
        rdy_ptr = 0; rdy_mode = 1'b1;
        send_cmd(2'b10, 32'h0, 8'd0);
        wait_idle("readout_done");
        rdy_mode = 1'b0;

        push_res(4'd0, 32'h13FF);
        push_res(4'd1, 32'h1400);
        send_cmd(2'b11, 32'h3FF, 8'd2);
        wait_idle("memrd_done");

        c0 = cs_count;
        send_cmd(2'b00, 32'h200, 8'd0);
        @(negedge clk);
        chk("load0_in_load", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("load0_ready_back", 64'(cmd_ready), 64'd1);
        chk("load0_no_cs", 64'(cs_count - c0), 64'd0);
        @(posedge clk); #1;

        send_cmd(2'b01, 32'h40, 8'd5);
        for (int w = 0; w < 3; w++) send_word(32'h11111111, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 64'({cmd_ready, busy, res_valid, in_ready, cim_cs, cim_cim, cim_partial_sum}), 64'b1000000);
        chk("abort_bus", {cim_address, cim_input_data}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        ps_log.delete(); c0 = clr_count;
        for (int j = 0; j < 8; j++) push_res(4'(j), exp5[j]);
        send_cmd(2'b01, 32'h100, 8'd2);
        send_word(32'h12345678, 0);
        send_word(32'h11111111, 0);
        wait_idle("mvm2_done");
        chk("mvm2_clr", 64'(clr_count - c0), 64'd1);
        chk("mvm2_ps_count", 64'(ps_log.size()), 64'd2);
        if (ps_log.size() == 2) begin
            chk("mvm2_ps_addr0", 64'(ps_log[0]), 64'h100);
            chk("mvm2_ps_addr1", 64'(ps_log[1]), 64'h108);
        end

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tb_busy = 0;
        for (int j = 0; j < 8; j++) push_res(4'(j), 32'(4 * (j + 1)));
        send_cmd(2'b01, 32'h0, 8'd4);
        send_word(32'h11111111, 0);
        send_word(32'h11111111, 1);
        send_word(32'h11111111, 1);
        send_word(32'h11111111, 0);
        wait_idle("mvm4_done");
        chk("busy_span", 64'(tb_busy), 64'd16);
`ifdef CIM_SEQ_PERF_EN
        chk("perf_busy", 64'(perf_busy_cycles), 64'd16);
        chk("perf_stall", 64'(perf_stall_cycles), 64'd2);
`else
        chk("perf_busy_tied", 64'(perf_busy_cycles), 64'd0);
        chk("perf_stall_tied", 64'(perf_stall_cycles), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
